// File: rtl/cnt_seq_ctrl.sv
// Programmable up/down run-to-value counter with one-shot or periodic reload,
// pause/abort, and a start/done handshake toward a host FSM.
module cnt_seq_ctrl #(
  parameter int DWIDTH = 7,
  parameter int RWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DWIDTH-1:0] cnt_val_i,
  input  logic              dir_i,
  input  logic              reload_i,
  input  logic [RWIDTH-1:0] rpt_i,
  input  logic              pause_i,
  input  logic              stop_i,
  output logic [DWIDTH-1:0] cnt_o,
  output logic              busy_o,
  output logic              tick_o,
  output logic              done_o,
  output logic [RWIDTH-1:0] period_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  typedef struct packed {
    logic [DWIDTH-1:0] tgt;
    logic              dir;
    logic              reload;
    logic [RWIDTH-1:0] rpt;
  } cfg_t;

  logic [0:0]        state;
  cfg_t              cfg;
  logic [DWIDTH-1:0] tv, sv;
  logic [RWIDTH-1:0] period_nxt;
  logic              at_tv, finish;

  // Terminal and start values swap with direction; T=0 makes them equal.
  assign tv         = cfg.dir ? '0 : cfg.tgt;
  assign sv         = cfg.dir ? cfg.tgt : '0;
  assign at_tv      = (cnt_o == tv);
  assign period_nxt = period_o + RWIDTH'(1);
  assign finish     = !cfg.reload || ((cfg.rpt != '0) && (period_nxt == cfg.rpt));
  assign busy_o     = (state == S_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cfg      <= '0;
      cnt_o    <= '0;
      tick_o   <= 1'b0;
      done_o   <= 1'b0;
      period_o <= '0;
    end else begin
      tick_o <= 1'b0;
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            cfg      <= '{tgt: cnt_val_i, dir: dir_i, reload: reload_i, rpt: rpt_i};
            cnt_o    <= dir_i ? cnt_val_i : '0;
            period_o <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (stop_i) begin
            state <= S_IDLE;
          end else if (!pause_i) begin
            if (!at_tv) begin
              cnt_o <= cfg.dir ? cnt_o - DWIDTH'(1) : cnt_o + DWIDTH'(1);
            end else begin
              // End of period; a paused terminal lands here once pause drops.
              tick_o   <= 1'b1;
              period_o <= period_nxt;
              if (finish) begin
                done_o <= 1'b1;
                state  <= S_IDLE;
              end else begin
                cnt_o <= sv;
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: expected per-cycle outputs are queued when a
// scenario is driven and popped/compared one per clock.
module tb_cnt_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i, dir_i, reload_i, pause_i, stop_i;
  logic [6:0] cnt_val_i;
  logic [3:0] rpt_i;
  logic [6:0] cnt_o;
  logic       busy_o, tick_o, done_o;
  logic [3:0] period_o;

  typedef struct packed {
    logic [6:0] cnt;
    logic       busy;
    logic       tick;
    logic       done;
    logic [3:0] period;
  } obs_t;

  obs_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  cnt_seq_ctrl #(.DWIDTH(7), .RWIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .cnt_val_i(cnt_val_i),
    .dir_i(dir_i), .reload_i(reload_i), .rpt_i(rpt_i), .pause_i(pause_i),
    .stop_i(stop_i), .cnt_o(cnt_o), .busy_o(busy_o), .tick_o(tick_o),
    .done_o(done_o), .period_o(period_o)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed run still active, required finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic push(input int c, input bit b, input bit t, input bit d, input int p);
    obs_t e;
    e.cnt = 7'(c); e.busy = b; e.tick = t; e.done = d; e.period = 4'(p);
    sb.push_back(e);
  endtask

  task automatic chk_now(input string tag);
    obs_t o, e;
    o = {cnt_o, busy_o, tick_o, done_o, period_o};
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL %s: observed %h with no expected entry queued", tag, o);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        n_err++;
        $error("FAIL %s: observed cnt=%0d busy=%0b tick=%0b done=%0b period=%0d, expected cnt=%0d busy=%0b tick=%0b done=%0b period=%0d",
               tag, o.cnt, o.busy, o.tick, o.done, o.period, e.cnt, e.busy, e.tick, e.done, e.period);
      end
    end
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    chk_now(tag);
  endtask

  task automatic cfg(input int t, input bit d, input bit r, input int rp);
    cnt_val_i = 7'(t); dir_i = d; reload_i = r; rpt_i = 4'(rp);
  endtask

  initial begin
    rst_n = 1'b0; start_i = 1'b0; pause_i = 1'b0; stop_i = 1'b0;
    cfg(0, 0, 0, 0);
    push(0, 0, 0, 0, 0);
    cyc("reset");
    push(0, 0, 0, 0, 0);
    cyc("reset_hold");
    rst_n = 1'b1;

    // Up one-shot T=5
    for (int k = 0; k <= 5; k++) push(k, 1, 0, 0, 0);
    push(5, 0, 1, 1, 1);
    push(5, 0, 0, 0, 1);
    cfg(5, 0, 0, 0); start_i = 1'b1;
    cyc("up c1"); start_i = 1'b0;
    for (int k = 2; k <= 8; k++) cyc($sformatf("up c%0d", k));

    // Down one-shot T=3
    for (int k = 3; k >= 0; k--) push(k, 1, 0, 0, 0);
    push(0, 0, 1, 1, 1);
    cfg(3, 1, 0, 0); start_i = 1'b1;
    cyc("dn c1"); start_i = 1'b0;
    for (int k = 2; k <= 5; k++) cyc($sformatf("dn c%0d", k));

    // Reload T=2 rpt=3, started in the cycle done is high
    push(0, 1, 0, 0, 0); push(1, 1, 0, 0, 0); push(2, 1, 0, 0, 0);
    push(0, 1, 1, 0, 1); push(1, 1, 0, 0, 1); push(2, 1, 0, 0, 1);
    push(0, 1, 1, 0, 2); push(1, 1, 0, 0, 2); push(2, 1, 0, 0, 2);
    push(2, 0, 1, 1, 3); push(2, 0, 0, 0, 3);
    cfg(2, 0, 1, 3); start_i = 1'b1;
    cyc("rl c1"); start_i = 1'b0;
    for (int k = 2; k <= 11; k++) cyc($sformatf("rl c%0d", k));

    // Pause mid-count and at the terminal value, T=4 one-shot
    push(0, 1, 0, 0, 0); push(1, 1, 0, 0, 0); push(2, 1, 0, 0, 0);
    push(2, 1, 0, 0, 0); push(2, 1, 0, 0, 0); push(3, 1, 0, 0, 0);
    push(4, 1, 0, 0, 0); push(4, 1, 0, 0, 0); push(4, 1, 0, 0, 0);
    push(4, 0, 1, 1, 1);
    push(4, 0, 0, 0, 1);
    cfg(4, 0, 0, 0); start_i = 1'b1;
    cyc("ps c1"); start_i = 1'b0;
    cyc("ps c2");
    cyc("ps c3"); pause_i = 1'b1;
    cyc("ps c4");
    cyc("ps c5"); pause_i = 1'b0;
    cyc("ps c6");
    cyc("ps c7"); pause_i = 1'b1;
    cyc("ps c8");
    cyc("ps c9"); pause_i = 1'b0;
    cyc("ps c10");
    stop_i = 1'b1; pause_i = 1'b1;
    cyc("ps idle_ign");
    stop_i = 1'b0; pause_i = 1'b0;

    // Unlimited reload T=1, start while busy ignored, stop+pause at TV
    push(0, 1, 0, 0, 0); push(1, 1, 0, 0, 0); push(0, 1, 1, 0, 1);
    push(1, 1, 0, 0, 1); push(0, 1, 1, 0, 2); push(1, 1, 0, 0, 2);
    push(1, 0, 0, 0, 2); push(1, 0, 0, 0, 2);
    cfg(1, 0, 1, 0); start_i = 1'b1;
    cyc("un c1");
    cfg(6, 1, 0, 5);
    cyc("un c2"); start_i = 1'b0;
    for (int k = 3; k <= 6; k++) cyc($sformatf("un c%0d", k));
    stop_i = 1'b1; pause_i = 1'b1;
    cyc("un stop");
    stop_i = 1'b0; pause_i = 1'b0;
    cyc("un idle");

    // T=0 reload rpt=2
    push(0, 1, 0, 0, 0); push(0, 1, 1, 0, 1); push(0, 0, 1, 1, 2); push(0, 0, 0, 0, 2);
    cfg(0, 0, 1, 2); start_i = 1'b1;
    cyc("t0 c1"); start_i = 1'b0;
    for (int k = 2; k <= 4; k++) cyc($sformatf("t0 c%0d", k));

    // Reset mid-run, then a normal start after release
    push(0, 1, 0, 0, 0); push(1, 1, 0, 0, 0); push(0, 1, 1, 0, 1); push(1, 1, 0, 0, 1);
    cfg(1, 0, 1, 0); start_i = 1'b1;
    cyc("rs c1"); start_i = 1'b0;
    for (int k = 2; k <= 4; k++) cyc($sformatf("rs c%0d", k));
    #2 rst_n = 1'b0;
    push(0, 0, 0, 0, 0);
    #1 chk_now("rs async");
    push(0, 0, 0, 0, 0);
    cyc("rs held");
    #2 rst_n = 1'b1;
    push(0, 1, 0, 0, 0); push(1, 1, 0, 0, 0); push(2, 1, 0, 0, 0); push(2, 0, 1, 1, 1);
    cfg(2, 0, 0, 0); start_i = 1'b1;
    cyc("ar c1"); start_i = 1'b0;
    for (int k = 2; k <= 4; k++) cyc($sformatf("ar c%0d", k));

    n_vec++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL sb_drain: observed %0d leftover entries, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cnt_seq_ctrl.md
# cnt_seq_ctrl

Programmable counter with its own control FSM and a start/done handshake. It extends the basic run-to-value counter with:
- up or down direction,
- one-shot or auto-reload (periodic) mode with a programmable repeat count,
- pause and abort.

It feeds timing ticks to datapath blocks and reports completion to a host FSM.

## Interface
- DWIDTH, 7, counter and target width
- RWIDTH, 4, repeat-count and period-counter width
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start_i  input  1  start request, sampled in IDLE only
- cnt_val_i  input  DWIDTH  target value T, latched on start
- dir_i  input  1  0 = count up 0→T, 1 = count down T→0; latched on start
- reload_i  input  1  0 = one-shot, 1 = auto-reload; latched on start
- rpt_i  input  RWIDTH  periods to run in reload mode, 0 = unlimited; latched on start
- pause_i  input  1  level; holds the counter while high in RUN
- stop_i  input  1  abort request, effective in RUN
- cnt_o  output  DWIDTH  current count
- busy_o  output  1  high while in RUN
- tick_o  output  1  one-cycle pulse at the end of each period
- done_o  output  1  one-cycle pulse on normal completion
- period_o  output  RWIDTH  completed periods since last start

## Operation
- Two states: IDLE and RUN. Reset (any time, including mid-run) forces IDLE immediately.
- Reset values: cnt_o=0, busy_o=0, tick_o=0, done_o=0, period_o=0, latched config=0.
- Start acceptance:
  - Only in IDLE with start_i=1. At that edge: latch T, dir, reload and rpt; period_o←0.
  - cnt_o←0 (up) or T (down); state←RUN.
  - start_i in RUN is ignored.
- Terminal value: TV = T (up) or 0 (down). Start value: SV = 0 (up) or T (down).
- RUN, per edge, in priority order:
  1. stop_i=1 → IDLE. cnt_o holds, no tick_o, no done_o.
  2. pause_i=1 → everything holds. A terminal event is deferred while paused.
  3. cnt_o≠TV → cnt_o±1.
  4. cnt_o==TV → end of period:
     - tick_o←1 and period_o←period_o+1 (wraps modulo 2^RWIDTH).
     - Finish if reload=0, or if reload=1, rpt≠0 and period_o+1==rpt. Finish means IDLE, done_o←1, cnt_o holds at TV.
     - Otherwise cnt_o←SV and stay in RUN.
- Unlimited mode (reload=1, rpt=0) runs until stop_i or reset. done_o never pulses in this mode.
- T=0: SV==TV, so every period lasts one cycle. This is legal.
- Count arithmetic is unsigned DWIDTH and never passes TV, so it cannot wrap.
- tick_o and done_o are registered and last one cycle. They deassert on the following edge regardless of state.
- stop_i and pause_i are ignored in IDLE.
- Outputs are held through IDLE until the next start. A new start clears period_o.

## Timing
- Start sampled at edge E0. busy_o=1 and cnt_o=SV from cycle 1.
- Each period is T+1 cycles in RUN, excluding paused cycles.
- One-shot: TV is present in cycle T+1. tick_o=done_o=1 and busy_o=0 in cycle T+2.
- Back-to-back periods have no gap: SV follows TV directly.
- A new start can be sampled in the cycle done_o is high. Restart gap is 1 cycle.
- stop_i at edge Ek → busy_o=0 from cycle k+1.
- pause_i high for N cycles extends the run by exactly N cycles.
- No combinational input-to-output paths.

## Test plan
- Up one-shot: T=5, dir=0, reload=0, start at cycle 0.
  - Required: cnt_o 0,1,2,3,4,5 in cycles 1–6.
  - Cycle 7: tick_o=done_o=1, busy_o=0, cnt_o=5, period_o=1.
- Down one-shot: T=3, dir=1.
  - Required: cnt_o 3,2,1,0 in cycles 1–4.
  - Cycle 5: done_o=1, cnt_o=0.
- Reload: T=2, dir=0, rpt=3.
  - Required: cnt_o 0,1,2,0,1,2,0,1,2.
  - tick_o in cycles 4, 7 and 10; period_o 1, 2, 3.
  - done_o in cycle 10 only; busy_o=0 from cycle 10.
- Pause and deferred terminal: T=4 one-shot, pause_i high during cycles 3–4, then high again while cnt_o=4.
  - Required: cnt_o holds 2 during the first pause.
  - done_o is delayed by the total paused cycles.
  - No tick_o while paused at TV.
- Stop with simultaneous events: unlimited reload, T=1.
  - stop_i and pause_i both high while cnt_o=1: IDLE next cycle, no tick_o/done_o, cnt_o=1.
  - start_i while busy: ignored.
- T=0 and reset mid-run:
  - T=0 reload, rpt=2: tick_o in cycles 2 and 3, done_o in cycle 3.
  - rst_n low during RUN: all outputs 0 immediately, IDLE.
  - A start after release is accepted normally.
